// File: rtl/ds_pkg.sv
// Shared constants for the DS-form memory sequencer: op codes, FSM encoding, DS displacement shift.
package ds_pkg;
  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_LDU  = 3'd1;
  localparam logic [2:0] OP_LWA  = 3'd2;
  localparam logic [2:0] OP_STD  = 3'd3;
  localparam logic [2:0] OP_STDU = 3'd4;
  localparam logic [2:0] OP_STQ  = 3'd5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_REQ2    = 3'd2;
  localparam logic [2:0] ST_WB_DATA = 3'd3;
  localparam logic [2:0] ST_WB_EA   = 3'd4;

  // DS immediates address 4-byte units
  localparam int IMM_SHIFT = 2;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_STD) || (op == OP_STDU) || (op == OP_STQ);
  endfunction
endpackage

// File: rtl/ds_ea_gen.sv
// DS/D-form effective address: (RA|0) + sext(imm << IMM_SHIFT), modulo 2^dataWidth.
module ds_ea_gen
  import ds_pkg::*;
#(
  parameter int regWidth  = 5,
  parameter int immWidth  = 14,
  parameter int dataWidth = 64
) (
  input  logic [regWidth-1:0]  i_reg2,
  input  logic                 i_reg2ValOrZero,
  input  logic [immWidth-1:0]  i_imm,
  input  logic [dataWidth-1:0] i_reg2Val,
  output logic [dataWidth-1:0] o_ea
);
  logic [dataWidth-1:0] w_base;
  logic [dataWidth-1:0] w_disp;

  assign w_base = (i_reg2ValOrZero && (i_reg2 == '0)) ? '0 : i_reg2Val;
  assign w_disp = {{(dataWidth-immWidth-IMM_SHIFT){i_imm[immWidth-1]}}, i_imm, {IMM_SHIFT{1'b0}}};
  assign o_ea   = w_base + w_disp;
endmodule

// File: rtl/ds_mem_sequencer.sv
// DS-form load/store sequencer: single-outstanding req/ack port, two beats for stq, GPR writeback.
// Optional DS_ALIGN_CHECK_EN adds alignErr_o and suppresses misaligned accesses.
module ds_mem_sequencer
  import ds_pkg::*;
#(
  parameter int regWidth  = 5,
  parameter int immWidth  = 14,
  parameter int dataWidth = 64,
  parameter int opWidth   = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [opWidth-1:0]   op_i,
  input  logic [regWidth-1:0]  reg1_i,
  input  logic [regWidth-1:0]  reg2_i,
  input  logic                 reg2ValOrZero_i,
  input  logic [immWidth-1:0]  imm_i,
  input  logic [dataWidth-1:0] reg2Val_i,
  input  logic [dataWidth-1:0] storeData_i,
  input  logic [dataWidth-1:0] storeData2_i,
  output logic                 ready_o,
  output logic                 memReq_o,
  output logic                 memWrite_o,
  output logic                 memWord_o,
  output logic [dataWidth-1:0] memAddr_o,
  output logic [dataWidth-1:0] memWData_o,
  input  logic                 memAck_i,
  input  logic [dataWidth-1:0] memRData_i,
`ifdef DS_ALIGN_CHECK_EN
  output logic                 alignErr_o,
`endif
  output logic                 wbEnable_o,
  output logic [regWidth-1:0]  wbReg_o,
  output logic [dataWidth-1:0] wbData_o
);
  localparam logic [dataWidth-1:0] BEAT_STRIDE = dataWidth'(8);

  logic [2:0]           r_state;
  logic [opWidth-1:0]   r_op;
  logic [regWidth-1:0]  r_rt, r_ra;
  logic [dataWidth-1:0] r_ea, r_sd, r_sd2, r_rdata;

  logic [dataWidth-1:0] w_ea;
  logic                 w_accept, w_mis, w_inReq, w_isLoad;

  ds_ea_gen #(.regWidth(regWidth), .immWidth(immWidth), .dataWidth(dataWidth)) u_ea (
    .i_reg2          (reg2_i),
    .i_reg2ValOrZero (reg2ValOrZero_i),
    .i_imm           (imm_i),
    .i_reg2Val       (reg2Val_i),
    .o_ea            (w_ea)
  );

  assign w_accept = enable_i && (r_state == ST_IDLE) && (op_i <= OP_STQ);
  assign w_isLoad = (r_op == OP_LD) || (r_op == OP_LDU) || (r_op == OP_LWA);

`ifdef DS_ALIGN_CHECK_EN
  logic r_alignErr;
  assign w_mis = (op_i == OP_STQ) ? |w_ea[3:0] :
                 (op_i == OP_LWA) ? |w_ea[1:0] : |w_ea[2:0];
  assign alignErr_o = r_alignErr;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_alignErr <= 1'b0;
    else         r_alignErr <= w_accept && w_mis;
  end
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_rt    <= '0;
      r_ra    <= '0;
      r_ea    <= '0;
      r_sd    <= '0;
      r_sd2   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op  <= op_i;
          r_rt  <= reg1_i;
          r_ra  <= reg2_i;
          r_ea  <= w_ea;
          r_sd  <= storeData_i;
          r_sd2 <= storeData2_i;
          if (!w_mis) r_state <= ST_REQ;
        end
        ST_REQ: if (memAck_i) begin
          if (w_isLoad) begin
            r_rdata <= (r_op == OP_LWA) ?
                       {{(dataWidth-32){memRData_i[31]}}, memRData_i[31:0]} : memRData_i;
            r_state <= ST_WB_DATA;
          end else if (r_op == OP_STQ)  r_state <= ST_REQ2;
          else if (r_op == OP_STDU)     r_state <= ST_WB_EA;
          else                          r_state <= ST_IDLE;
        end
        ST_REQ2:    if (memAck_i) r_state <= ST_IDLE;
        ST_WB_DATA: r_state <= (r_op == OP_LDU) ? ST_WB_EA : ST_IDLE;
        ST_WB_EA:   r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops memReq_o at once
  assign w_inReq = (r_state == ST_REQ) || (r_state == ST_REQ2);

  always_comb begin
    ready_o    = (r_state == ST_IDLE);
    memReq_o   = w_inReq;
    memWrite_o = w_inReq && is_store(r_op);
    memWord_o  = w_inReq && (r_op == OP_LWA);
    memAddr_o  = '0;
    memWData_o = '0;
    wbEnable_o = 1'b0;
    wbReg_o    = '0;
    wbData_o   = '0;
    if (r_state == ST_REQ) begin
      memAddr_o  = r_ea;
      memWData_o = is_store(r_op) ? r_sd : '0;
    end else if (r_state == ST_REQ2) begin
      memAddr_o  = r_ea + BEAT_STRIDE;
      memWData_o = r_sd2;
    end else if (r_state == ST_WB_DATA) begin
      wbEnable_o = 1'b1;
      wbReg_o    = r_rt;
      wbData_o   = r_rdata;
    end else if (r_state == ST_WB_EA) begin
      wbEnable_o = 1'b1;
      wbReg_o    = r_ra;
      wbData_o   = r_ea;
    end
  end
endmodule

// File: tb/tb_ds_mem_sequencer.sv
// Bench for ds_mem_sequencer: transaction-level model (expected beats / writebacks / busy time) checked every cycle.
module tb_ds_mem_sequencer;
`ifdef DS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clock_i = 1'b0, reset_i = 1'b1, enable_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [4:0]  reg1_i = '0, reg2_i = '0;
  logic        reg2ValOrZero_i = 1'b0;
  logic [13:0] imm_i = '0;
  logic [63:0] reg2Val_i = '0, storeData_i = '0, storeData2_i = '0, memRData_i = '0;
  logic        memAck_i = 1'b0;
  logic        ready_o, memReq_o, memWrite_o, memWord_o, wbEnable_o;
  logic [63:0] memAddr_o, memWData_o, wbData_o;
  logic [4:0]  wbReg_o;
`ifdef DS_ALIGN_CHECK_EN
  logic        alignErr_o;
`endif

  ds_mem_sequencer dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .op_i(op_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .reg2ValOrZero_i(reg2ValOrZero_i), .imm_i(imm_i),
    .reg2Val_i(reg2Val_i), .storeData_i(storeData_i), .storeData2_i(storeData2_i),
    .ready_o(ready_o), .memReq_o(memReq_o), .memWrite_o(memWrite_o), .memWord_o(memWord_o),
    .memAddr_o(memAddr_o), .memWData_o(memWData_o), .memAck_i(memAck_i), .memRData_i(memRData_i),
`ifdef DS_ALIGN_CHECK_EN
    .alignErr_o(alignErr_o),
`endif
    .wbEnable_o(wbEnable_o), .wbReg_o(wbReg_o), .wbData_o(wbData_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic wr; logic wd; } beat_t;
  typedef struct { logic [4:0] rg; logic [63:0] data; } wb_t;

  beat_t exp_beats[$];
  wb_t   exp_wbs[$];
  int checks = 0, errors = 0;
  int busy_cnt = 0, last_busy = -1, wb_count = 0, align_cnt = 0;
  logic [63:0] last_addr = '0, last_wdata = '0, last_wb_data = '0;
  logic [4:0]  last_wb_reg = '0;
  logic        last_word = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_ea(input logic [4:0] ra, input logic rz,
                                       input logic [13:0] imm, input logic [63:0] v);
    logic signed [63:0] d;
    logic [63:0] base;
    d = $signed(imm);
    base = (rz && ra == 5'd0) ? 64'd0 : v;
    return base + d * 4;
  endfunction

  // Per-cycle compare against the expectation queues
  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (!ready_o) busy_cnt++;
      else if (busy_cnt != 0) begin last_busy = busy_cnt; busy_cnt = 0; end
`ifdef DS_ALIGN_CHECK_EN
      if (alignErr_o) align_cnt++;
`endif
      if (memReq_o) begin
        if (exp_beats.size() == 0) chk("unexpected_req", memReq_o, 1'b0);
        else begin
          chk("req_addr", memAddr_o, exp_beats[0].addr);
          chk("req_write", memWrite_o, exp_beats[0].wr);
          chk("req_word", memWord_o, exp_beats[0].wd);
          if (exp_beats[0].wr) chk("req_wdata", memWData_o, exp_beats[0].wdata);
          if (memAck_i) begin
            last_addr = memAddr_o; last_wdata = memWData_o; last_word = memWord_o;
            void'(exp_beats.pop_front());
          end
        end
      end
      if (wbEnable_o) begin
        wb_count++;
        if (exp_wbs.size() == 0) chk("unexpected_wb", wbEnable_o, 1'b0);
        else begin
          chk("wb_reg", wbReg_o, exp_wbs[0].rg);
          chk("wb_data", wbData_o, exp_wbs[0].data);
          last_wb_reg = wbReg_o; last_wb_data = wbData_o;
          void'(exp_wbs.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (1) begin
      @(negedge clock_i); #1;
      if (ready_o) break;
      if (++n > 50) begin chk(name, 1'b0, 1'b1); break; end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rt, input logic [4:0] ra,
                       input logic rz, input logic [13:0] imm, input logic [63:0] base,
                       input logic [63:0] sd, input logic [63:0] sd2, input logic [63:0] rdata,
                       input int d);
    logic [63:0] ea;
    logic mis;
    int nbeats, busy, al0;
    wait_ready("timeout_ready_pre");
    ea = m_ea(ra, rz, imm, base);
    mis = ALIGN && ((op == 3'd5) ? (ea % 16 != 0) : (op == 3'd2) ? (ea % 4 != 0) : (ea % 8 != 0));
    nbeats = mis ? 0 : (op == 3'd5) ? 2 : 1;
    busy = (op == 3'd1) ? 3 : (op == 3'd3) ? 1 : 2;
    if (!mis) begin
      exp_beats.push_back('{ea, sd, op >= 3'd3, op == 3'd2});
      if (op == 3'd5) exp_beats.push_back('{ea + 64'd8, sd2, 1'b1, 1'b0});
      if (op <= 3'd2)
        exp_wbs.push_back('{rt, (op == 3'd2) ? {{32{rdata[31]}}, rdata[31:0]} : rdata});
      if (op == 3'd1 || op == 3'd4) exp_wbs.push_back('{ra, ea});
    end
    al0 = align_cnt;
    last_busy = -1;
    op_i = op; reg1_i = rt; reg2_i = ra; reg2ValOrZero_i = rz; imm_i = imm;
    reg2Val_i = base; storeData_i = sd; storeData2_i = sd2; enable_i = 1'b1;
    @(posedge clock_i); #1 enable_i = 1'b0;
    if (nbeats > 0) begin
      repeat (d) begin @(posedge clock_i); #1; end
      memAck_i = 1'b1; memRData_i = rdata;
      repeat (nbeats) @(posedge clock_i);
      #1 memAck_i = 1'b0;
      wait_ready("timeout_ready_post");
      chk("busy_cycles", 64'(last_busy), 64'(busy + d));
    end else begin
      @(negedge clock_i); #1;
      chk("align_ready", ready_o, 1'b1);
      chk("align_err_pulse", 64'(align_cnt - al0), 64'd1);
    end
    chk("beats_drained", 64'(exp_beats.size()), 64'd0);
    chk("wbs_drained", 64'(exp_wbs.size()), 64'd0);
  endtask

  initial begin
    int wb0;
    #12;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_req", {memReq_o, memWrite_o, memWord_o, wbEnable_o}, 4'b0);
    chk("rst_addr", memAddr_o, 64'd0);
    chk("rst_wdata", memWData_o, 64'd0);
    chk("rst_wbreg", wbReg_o, 5'd0);
    chk("rst_wbdata", wbData_o, 64'd0);
    @(negedge clock_i); reset_i = 1'b0;

    // LD, two wait cycles
    wb0 = wb_count;
    issue(3'd0, 5'd7, 5'd3, 1'b0, 14'h0002, 64'h1000, 64'h0, 64'h0, 64'hDEADBEEF_CAFEF00D, 2);
    chk("ld_addr_lit", last_addr, 64'h1008);
    chk("ld_wb_lit", last_wb_data, 64'hDEADBEEF_CAFEF00D);
    chk("ld_wb_reg_lit", last_wb_reg, 5'd7);
    chk("ld_one_wb", 64'(wb_count - wb0), 64'd1);

    // LWA off literal-zero base with imm = -1
    issue(3'd2, 5'd8, 5'd0, 1'b1, 14'h3FFF, 64'h5555, 64'h0, 64'h0, 64'h12345678_80000001, 0);
    chk("lwa_addr_lit", last_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("lwa_word_lit", last_word, 1'b1);
    chk("lwa_wb_lit", last_wb_data, 64'hFFFF_FFFF_8000_0001);

    // STDU
    issue(3'd4, 5'd6, 5'd5, 1'b0, 14'h0004, 64'h2000, 64'h1234, 64'h0, 64'h0, 0);
    chk("stdu_wdata_lit", last_wdata, 64'h1234);
    chk("stdu_wb_reg_lit", last_wb_reg, 5'd5);
    chk("stdu_wb_data_lit", last_wb_data, 64'h2010);

    // STQ, ack held high across both beats
    issue(3'd5, 5'd10, 5'd9, 1'b0, 14'h0000, 64'h4000, 64'hAAAA, 64'hBBBB, 64'h0, 0);
    chk("stq_addr2_lit", last_addr, 64'h4008);
    chk("stq_wdata2_lit", last_wdata, 64'hBBBB);

    // Mixed patterns: STD w/ wait, LDU with negative imm, rz set but RA!=0
    issue(3'd3, 5'd2, 5'd11, 1'b0, 14'h0010, 64'h8000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 1);
    issue(3'd1, 5'd12, 5'd4, 1'b0, 14'h3FFE, 64'h100, 64'h0, 64'h0, 64'h5A5A_0000_1111_2222, 0);
    chk("ldu_ea_lit", last_wb_data, 64'hF8);
    issue(3'd0, 5'd1, 5'd2, 1'b1, 14'h0001, 64'h7000, 64'h0, 64'h0, 64'h0000_0000_0000_0042, 3);
    chk("ld_rz_addr_lit", last_addr, 64'h7004);

    // Unsupported ops are ignored
    for (int k = 6; k <= 7; k++) begin
      op_i = 3'(k); enable_i = 1'b1;
      @(posedge clock_i); #1 enable_i = 1'b0;
      @(negedge clock_i);
      chk("unsup_ready", ready_o, 1'b1);
      chk("unsup_req", memReq_o, 1'b0);
    end

    // Misaligned STQ: issued unchanged, or rejected when alignment checking is built in
    issue(3'd5, 5'd14, 5'd13, 1'b0, 14'h0002, 64'h4000, 64'hCCCC, 64'hDDDD, 64'h0, 0);

    // Reset while LDU waits for ack
    wait_ready("timeout_ready_rst");
    op_i = 3'd1; reg1_i = 5'd3; reg2_i = 5'd4; reg2ValOrZero_i = 1'b0; imm_i = 14'h0;
    reg2Val_i = 64'h300; enable_i = 1'b1;
    exp_beats.push_back('{64'h300, 64'h0, 1'b0, 1'b0});
    @(posedge clock_i); #1 enable_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #2 reset_i = 1'b1;
    #1;
    chk("rst_mid_req", memReq_o, 1'b0);
    chk("rst_mid_ready", ready_o, 1'b1);
    chk("rst_mid_wb", wbEnable_o, 1'b0);
    exp_beats.delete(); exp_wbs.delete(); busy_cnt = 0;
    #1 reset_i = 1'b0;
    wb0 = wb_count;
    repeat (4) @(negedge clock_i);
    chk("rst_no_wb", 64'(wb_count - wb0), 64'd0);

    // Recovers after reset
    issue(3'd0, 5'd9, 5'd6, 1'b0, 14'h0008, 64'h10, 64'h0, 64'h0, 64'hFEED, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=0", 1);
    $fatal(1);
  end
endmodule

// File: doc/ds_mem_sequencer.md
Name: ds_mem_sequencer

Overview:
- Sequences integer DS-form memory ops (ld, ldu, lwa, std, stdu, stq) after decode.
- Forms the effective address and drives a single-outstanding req/ack memory port, issuing two beats for stq.
- Writes the load result and/or updated base register back to the GPR file.
- Sits between the DS-format decoder stage and the data-memory interface; stalls the decoder via ready_o.

Parameters:
- regWidth, 5, GPR address width
- immWidth, 14, DS immediate field width
- dataWidth, 64, GPR / memory data width
- opWidth, 3, operation code width

Ports:
- clock_i  in  1  clock
- reset_i  in  1  reset; one clock; reset is asynchronous and active-high
- enable_i  in  1  decoded op valid
- op_i  in  3  0 LD, 1 LDU, 2 LWA, 3 STD, 4 STDU, 5 STQ, 6-7 unsupported
- reg1_i  in  5  RT/RS
- reg2_i  in  5  RA
- reg2ValOrZero_i  in  1  RA==0 means literal zero base
- imm_i  in  14  DS field
- reg2Val_i  in  64  GPR[RA] contents
- storeData_i  in  64  GPR[RS]
- storeData2_i  in  64  GPR[RS+1] (stq)
- ready_o  out  1  sequencer idle, can accept
- memReq_o  out  1  memory request valid
- memWrite_o  out  1  1 store, 0 load
- memWord_o  out  1  1 word access, 0 doubleword
- memAddr_o  out  64  effective address
- memWData_o  out  64  store data
- memAck_i  in  1  request accepted; carries read data for loads
- memRData_i  in  64  read data; word returned in bits 32:63
- wbEnable_o  out  1  GPR write strobe (one cycle)
- wbReg_o  out  5  GPR write address
- wbData_o  out  64  GPR write data

Behaviour:
- Reset values: ready_o=1; memReq_o, memWrite_o, memWord_o, wbEnable_o = 0; memAddr_o, memWData_o, wbReg_o, wbData_o = 0; state IDLE.
- Accept when enable_i && ready_o in IDLE.
  - Latch op, registers and store data.
  - EA = base + sext64({imm_i,2'b00}); base = 0 if reg2ValOrZero_i && reg2_i==0, else reg2Val_i. Addition mod 2^64.
  - ready_o drops the next cycle.
- Unsupported op (6,7): not accepted as work; ready_o stays 1; no outputs change.
- States: IDLE -> REQ -> {REQ2 | WB_DATA | WB_EA | IDLE}; REQ2 -> IDLE; WB_DATA -> {WB_EA | IDLE}; WB_EA -> IDLE.
  - REQ: memReq_o=1 from cycle after accept; addr, data, write, word held stable until memAck_i.
    - Ack on load -> WB_DATA.
    - Ack on STQ -> REQ2.
    - Ack on STDU -> WB_EA.
    - Ack on STD -> IDLE.
  - REQ2 (STQ only): memAddr_o = EA+8, memWData_o = storeData2_i latch. RS goes to EA, RS+1 to EA+8. Ack -> IDLE.
  - WB_DATA: wbEnable_o=1 one cycle, wbReg_o=RT.
    - LD/LDU: wbData_o = memRData_i captured at ack.
    - LWA: sign-extend bits 32:63.
    - LDU -> WB_EA; others -> IDLE.
  - WB_EA: wbEnable_o=1, wbReg_o=RA, wbData_o=EA; -> IDLE.
- memReq_o deasserts in the cycle after ack is sampled; back-to-back REQ->REQ2 keeps memReq_o high with the new address.
- ready_o returns 1 on entry to IDLE; a new op is accepted that same cycle.
- Minimum occupancy:
  - LD: 3 cycles (accept, REQ w/ immediate ack, WB).
  - STD: 2 cycles.
  - LDU/STDU: +1 cycle.
  - STQ: 3 cycles.
- memAck_i outside REQ/REQ2: ignored.
- Reset mid-operation: all state cleared asynchronously, memReq_o drops immediately, pending writeback is lost.
- LDU with RA==RT or RA==0 is not checked; the sequence runs as specified (EA writeback last wins).

Optional Feature:
- Macro: DS_ALIGN_CHECK_EN.
- Enabled: adds output alignErr_o (1 bit, reset 0).
  - Misaligned when EA[62:63]!=0 for word, EA[61:63]!=0 for doubleword, EA[60:63]!=0 for STQ.
  - Misaligned ops issue no memory request and no writeback.
  - alignErr_o pulses 1 cycle after accept; state returns IDLE.
- Disabled: port absent; no checking; misaligned addresses are issued unchanged.

Decomposition:
- Shared package ds_pkg:
  - op code localparams LD..STQ
  - state encoding
  - DS immediate shift constant (2)
- One natural sub-module, ds_ea_gen: combinational base select + sext/shift + add, reusable by the D-form path.

Test Plan:
- LD: RA=3 val 0x1000, imm=0x0002, ack after 2 wait cycles with data 0xDEADBEEF_CAFEF00D -> memAddr_o=0x1008, wb RT data 0xDEADBEEF_CAFEF00D, one wb pulse, ready_o back to 1.
- LWA with RA=0, reg2ValOrZero_i=1, imm=0x3FFF (−1) -> memAddr_o=0xFFFF_FFFF_FFFF_FFFC, memWord_o=1, rdata low word 0x80000001 -> wbData_o=0xFFFF_FFFF_8000_0001.
- STDU: RA=5 val 0x2000, imm=0x0004, RS data 0x1234 -> write at 0x2010 data 0x1234, then wb RA=5 data 0x2010.
- STQ: EA 0x4000, RS 0xAAAA, RS+1 0xBBBB, ack held high -> consecutive beats 0x4000/0xAAAA, 0x4008/0xBBBB, memReq_o continuous for 2 cycles.
- LDU held in REQ, reset_i asserted -> memReq_o falls without clock edge, no wbEnable_o, ready_o=1.
- DS_ALIGN_CHECK_EN build: STQ at EA 0x4008 -> alignErr_o pulse, no memReq_o; op_i=6 with enable_i -> ignored, ready_o stays 1.
